// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one bit-per-clock UART transmitter between NUM_REQ producers.
// Optional sticky-lock feature for uninterleaved multi-byte messages: UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int IDX_W      = 2,
   parameter int FRAME_WAIT = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]   req_lock,
`endif
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_load,
   output logic [7:0]           tx_data,
   output logic                 busy,
   output logic [IDX_W-1:0]     grant_id
);

   localparam int unsigned      N_U      = NUM_REQ;
   localparam int               EXT_N    = 2 ** IDX_W;
   localparam int               CNT_W    = $clog2(FRAME_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FRAME_WAIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [IDX_W-1:0] r_last;
   logic [IDX_W-1:0] r_grant;
   logic             r_tx_load;
   logic [7:0]       r_tx_data;

   logic [EXT_N-1:0] w_valid_ext;
   logic [IDX_W-1:0] w_rr_win;
   logic [IDX_W-1:0] w_win;
   logic             w_found;
   logic             w_xfer;
   logic [7:0]       w_win_data;

   // Pad valid to a power-of-two vector so IDX_W-wide indices are always in range.
   always_comb begin
      w_valid_ext                = '0;
      w_valid_ext[NUM_REQ-1:0]   = req_valid;
   end

   always_comb begin
      w_rr_win = r_last;
      w_found  = 1'b0;
      for (int unsigned k = 1; k <= N_U; k++) begin
         if (!w_found && w_valid_ext[IDX_W'((32'(r_last) + k) % N_U)]) begin
            w_rr_win = IDX_W'((32'(r_last) + k) % N_U);
            w_found  = 1'b1;
         end
      end
   end

`ifdef UART_TX_ARB_LOCK_EN
   logic             r_lock;
   logic [EXT_N-1:0] w_lock_ext;

   always_comb begin
      w_lock_ext              = '0;
      w_lock_ext[NUM_REQ-1:0] = req_lock;
   end

   // A locked requester that is still valid overrides the rotation; w_found is unaffected.
   assign w_win = (r_lock && w_valid_ext[r_last]) ? r_last : w_rr_win;
`else
   assign w_win = w_rr_win;
`endif

   assign w_xfer = (r_state == ST_IDLE) && w_found;

   always_comb begin
      req_ready  = '0;
      w_win_data = '0;
      for (int unsigned j = 0; j < N_U; j++) begin
         if (w_win == IDX_W'(j)) begin
            req_ready[j] = w_xfer;
            w_win_data   = req_data[j*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= '0;
         r_last     <= IDX_W'(NUM_REQ - 1);
         r_grant    <= '0;
         r_tx_load  <= 1'b0;
         r_tx_data  <= '0;
`ifdef UART_TX_ARB_LOCK_EN
         r_lock     <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_tx_data <= w_win_data;
                  r_tx_load <= 1'b1;
                  r_grant   <= w_win;
                  r_last    <= w_win;
                  r_state   <= ST_LOAD;
`ifdef UART_TX_ARB_LOCK_EN
                  r_lock    <= w_lock_ext[w_win];
`endif
               end
            end
            ST_LOAD: begin
               r_tx_load  <= 1'b0;
               r_wait_cnt <= CNT_INIT;
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_wait_cnt == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_load  = r_tx_load;
   assign tx_data  = r_tx_data;
   assign grant_id = r_grant;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized + directed bench for uart_tx_arbiter against a cycle-count reference model.
// Lock behaviour is modelled and driven only when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int IW  = 2;
   localparam int FW  = 10;
   localparam int GAP = FW + 2;
`ifdef UART_TX_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*8-1:0]  req_data = '0;
`ifdef UART_TX_ARB_LOCK_EN
   logic [N-1:0]    req_lock = '0;
`endif
   logic [N-1:0]    req_ready;
   logic            tx_load;
   logic [7:0]      tx_data;
   logic            busy;
   logic [IW-1:0]   grant_id;

   uart_tx_arbiter #(
      .NUM_REQ    (N),
      .IDX_W      (IW),
      .FRAME_WAIT (FW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
`ifdef UART_TX_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_ready (req_ready),
      .tx_load   (tx_load),
      .tx_data   (tx_data),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: a frame occupies GAP cycles from the transfer decision onward.
   int          m_next_ok  = 0;
   int          m_load_cyc = -1;
   int          m_last     = N - 1;
   int          m_grant    = 0;
   logic [7:0]  m_txd      = '0;
   bit          m_lock     = 1'b0;

   bit [N-1:0]  pend = '0;
   bit [N-1:0]  lk   = '0;
   logic [7:0]  byt [N];

   int gq[$];
   int lq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(input bit [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // Entered just after a rising edge; leaves just after the next one.
   task automatic step();
      int w;
      cyc++;
      check("tx_load",  32'(tx_load),  32'(cyc == m_load_cyc));
      check("busy",     32'(busy),     32'(cyc < m_next_ok));
      check("tx_data",  32'(tx_data),  32'(m_txd));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      if (tx_load) begin
         gq.push_back(int'(grant_id));
         lq.push_back(cyc);
      end
      req_valid = pend;
      for (int j = 0; j < N; j++) req_data[j*8 +: 8] = byt[j];
`ifdef UART_TX_ARB_LOCK_EN
      req_lock = lk;
`endif
      #1;
      w = -1;
      if (cyc >= m_next_ok) begin
         w = pick(pend, m_last);
         if (LOCK_EN && m_lock && pend[m_last]) w = m_last;
      end
      check("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
      check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (w >= 0) begin
         m_txd      = byt[w];
         m_grant    = w;
         m_last     = w;
         m_load_cyc = cyc + 1;
         m_next_ok  = cyc + GAP;
         m_lock     = lk[w];
         pend[w]    = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // Reset lands mid-cycle; outputs are checked before any clock edge can occur.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_tx_load",  32'(tx_load),  32'd0);
      check("rst_tx_data",  32'(tx_data),  32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      m_next_ok  = 0;
      m_load_cyc = -1;
      m_last     = N - 1;
      m_grant    = 0;
      m_txd      = '0;
      m_lock     = 1'b0;
      pend       = '0;
      lk         = '0;
      req_valid  = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      gq.delete();
      lq.delete();
   endtask

   initial begin
      int sent3;
      bit was3;
      int exp_seq[$];
      for (int j = 0; j < N; j++) byt[j] = '0;

      // Single requester 2 with A5
      do_reset();
      pend[2] = 1'b1;
      byt[2]  = 8'hA5;
      repeat (16) step();
      check("a5_loads", 32'(lq.size()), 32'd1);
      if (gq.size() > 0) check("a5_grant", 32'(gq[0]), 32'd2);

      // All requesters continuously valid
      do_reset();
      for (int i = 0; i < 62; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!pend[j]) begin
               pend[j] = 1'b1;
               byt[j]  = 8'(8'h10 + j);
            end
         end
         step();
      end
      check("rr_count", 32'(gq.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < gq.size(); k++) check("rr_order", 32'(gq[k]), 32'(k % N));
      for (int k = 1; k < 5 && k < lq.size(); k++) check("rr_spacing", 32'(lq[k] - lq[k-1]), 32'(GAP));

      // Requester 1 arrives during WAIT
      do_reset();
      pend[0] = 1'b1;
      byt[0]  = 8'h3C;
      repeat (3) step();
      pend[1] = 1'b1;
      byt[1]  = 8'h5A;
      repeat (25) step();
      check("late_count", 32'(gq.size()), 32'd2);
      if (gq.size() == 2) check("late_grant", 32'(gq[1]), 32'd1);

      // Reset four cycles after the load pulse, then 0 and 3 compete
      pend[1] = 1'b1;
      byt[1]  = 8'h99;
      repeat (5) step();
      do_reset();
      pend[0] = 1'b1; byt[0] = 8'h01;
      pend[3] = 1'b1; byt[3] = 8'h03;
      repeat (3) step();
      check("post_rst_count", 32'(gq.size()), 32'd1);
      if (gq.size() > 0) check("post_rst_grant", 32'(gq[0]), 32'd0);

      // Req 3 sends three bytes (lock on the first two) while req 0 stays valid
      do_reset();
      sent3 = 0;
      for (int i = 0; i < 80; i++) begin
         if (!pend[3] && sent3 < 3) begin
            pend[3] = 1'b1;
            byt[3]  = 8'(8'hC0 + sent3);
            lk[3]   = (sent3 < 2);
         end
         if (i > 0 && !pend[0]) begin
            pend[0] = 1'b1;
            byt[0]  = 8'(8'h70 + i);
         end
         was3 = pend[3];
         step();
         if (was3 && !pend[3]) sent3++;
      end
      if (LOCK_EN) exp_seq = '{3, 3, 3, 0};
      else         exp_seq = '{3, 0, 3, 0, 3};
      check("lock_count", 32'(gq.size() >= exp_seq.size()), 32'd1);
      for (int k = 0; k < exp_seq.size() && k < gq.size(); k++) check("lock_seq", 32'(gq[k]), 32'(exp_seq[k]));

      // Random traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!pend[j] && $urandom_range(0, 3) == 0) begin
               pend[j] = 1'b1;
               byt[j]  = 8'($urandom);
               lk[j]   = 1'($urandom_range(0, 1));
            end
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
